// File: rtl/ro_puf_pkg.sv
// Shared types and default sizing for the ring-oscillator PUF measurement sequencer.
package ro_puf_pkg;

    localparam int unsigned NUM_RO_DEF     = 9;
    localparam int unsigned CNT_W_DEF      = 16;
    localparam int unsigned WINDOW_DEF     = 65536;
    localparam int unsigned SETTLE_CYC_DEF = 4;
    localparam int unsigned CFG_W          = 6;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StMeasure,
        StSettle,
        StCapture,
        StCompare,
        StFinish
    } state_e;

endpackage

// File: rtl/ro_puf_window_timer.sv
// Loadable down-counter with a zero flag; shared by the measure and settle phases.
module ro_puf_window_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             zero
);

    logic [WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WIDTH'(1);
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/ro_puf_sequencer.sv
// Sequences one measurement per ring oscillator, then compares adjacent counts into a response.
module ro_puf_sequencer
    import ro_puf_pkg::*;
#(
    parameter int unsigned NUM_RO     = NUM_RO_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF,
    parameter int unsigned WINDOW     = WINDOW_DEF,
    parameter int unsigned SETTLE_CYC = SETTLE_CYC_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 challenge,
    input  logic [CNT_W-1:0]           ro_count,
    output logic [CFG_W-1:0]           ro_cfg,
    output logic [$clog2(NUM_RO)-1:0]  ro_sel,
    output logic                       ro_en,
    output logic                       cnt_clr,
    output logic                       busy,
    output logic                       done,
    output logic [NUM_RO-2:0]          response
);

    localparam int unsigned SEL_W = $clog2(NUM_RO);
    localparam int unsigned TMR_W = $clog2((WINDOW > SETTLE_CYC) ? WINDOW : SETTLE_CYC);
    localparam logic [TMR_W-1:0] WIN_LOAD = TMR_W'(WINDOW - 1);
    localparam logic [TMR_W-1:0] SET_LOAD = TMR_W'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(NUM_RO - 1);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q;
    logic [CFG_W-1:0]   cfg_q;
    logic               en_q, clr_q, busy_q, done_q;
    logic [NUM_RO-2:0]  resp_q, resp_d;
    logic [CNT_W-1:0]   count_q [NUM_RO];
    logic               tmr_load, tmr_zero;
    logic [TMR_W-1:0]   tmr_val;
    logic               accept, last;

    // A held START is taken straight out of FINISH so runs go back-to-back.
    assign accept = start && ((state_q == StIdle) || (state_q == StFinish));
    assign last   = (sel_q == LAST_SEL);

    ro_puf_window_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d  = state_q;
        tmr_load = 1'b0;
        tmr_val  = WIN_LOAD;
        unique case (state_q)
            StIdle:    if (start) state_d = StClear;
            StClear: begin
                state_d  = StMeasure;
                tmr_load = 1'b1;
                tmr_val  = WIN_LOAD;
            end
            StMeasure: begin
                if (tmr_zero) begin
                    state_d  = StSettle;
                    tmr_load = 1'b1;
                    tmr_val  = SET_LOAD;
                end
            end
            StSettle:  if (tmr_zero) state_d = StCapture;
            StCapture: state_d = last ? StCompare : StClear;
            StCompare: state_d = StFinish;
            StFinish:  state_d = start ? StClear : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_comb begin
        resp_d = '0;
        for (int i = 0; i < NUM_RO - 1; i++) begin
            resp_d[i] = (count_q[i+1] > count_q[i]);
        end
    end

    // Outputs are registered from the next state so the oscillator enable never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sel_q   <= '0;
            cfg_q   <= '0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            en_q    <= (state_d == StMeasure);
            clr_q   <= (state_d == StClear);
            busy_q  <= (state_d != StIdle);
            done_q  <= (state_d == StFinish);
            if (accept) begin
                cfg_q <= challenge[CFG_W-1:0];
                sel_q <= '0;
            end else if ((state_q == StCapture) && !last) begin
                sel_q <= sel_q + SEL_W'(1);
            end
            if (state_q == StCompare) begin
                resp_q <= resp_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_RO; i++) begin
                count_q[i] <= '0;
            end
        end else if (state_q == StCapture) begin
            count_q[sel_q] <= ro_count;
        end
    end

    assign ro_cfg   = cfg_q;
    assign ro_sel   = sel_q;
    assign ro_en    = en_q;
    assign cnt_clr  = clr_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign response = resp_q;

endmodule
